// File: rtl/intctl_pkg.sv
// intctl_pkg: shared register map and CTRL bit positions for the ZX-bus
// interrupt controller (intctl and intctl_chan).
package intctl_pkg;

   localparam logic [1:0] REG_PEND = 2'd0;
   localparam logic [1:0] REG_MASK = 2'd1;
   localparam logic [1:0] REG_MODE = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   localparam int CTRL_GEN = 0;
   localparam int CTRL_TMO = 7;

endpackage : intctl_pkg

// File: rtl/intctl_chan.sv
// intctl_chan: one interrupt channel.
// Synchronises the (already polarity-corrected) source, detects rising edges
// and keeps the per-channel pending bit in level or edge mode.
module intctl_chan (
   input  logic clk,
   input  logic rst,
   input  logic act,      // source after SRC_INV, asynchronous to clk
   input  logic mode,     // 1 = edge, 0 = level (value in force this cycle)
   input  logic w1c,      // clear request; only honoured in edge mode
   output logic pending
);

   logic s1, s2, s3;
   logic rise;

   // Two-flop synchroniser plus one extra stage for edge detection.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would
   // collapse the synchroniser chain into a single flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= act;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   // Level mode tracks s2; edge mode sets on a rise, which beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
      end else if (!mode) begin
         pending <= s2;
      end else begin
         pending <= rise | (pending & ~w1c);
      end
   end

endmodule : intctl_chan

// File: rtl/intctl.sv
// intctl: parametrised interrupt controller for the ZX-bus expansion CPLD.
// Register file (PEND/MASK/MODE/CTRL), read mux, masked request flop and
// open-drain output enable for the ZX INT line.
// Optional feature: define INTCTL_TIMEOUT_EN to force-release int_req after
// TMO_CYC cycles and report it in CTRL bit 7.
module intctl
   import intctl_pkg::*;
#(
   parameter int              N_CH    = 4,
   parameter logic [N_CH-1:0] SRC_INV = N_CH'(1),
   parameter int              TMO_CYC = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] src,
   input  logic            wr_stb,
   input  logic [1:0]      addr,
   input  logic [7:0]      wrdata,
   output logic [7:0]      rddata,
   output logic            int_req,
   output logic            zint_oe
);

   logic            wr_pend, wr_mask, wr_mode, wr_ctrl;
   logic [N_CH-1:0] mask, mode, pending;
   logic [N_CH-1:0] mask_eff, mode_eff, chan_w1c, act;
   logic            gen, gen_eff;
   logic            cond, req_nxt, tmo_rd;
   logic            unused_wrdata;

   // Not every wrdata bit maps to a register bit.
   assign unused_wrdata = &{1'b0, wrdata};

   assign wr_pend = wr_stb & (addr == REG_PEND);
   assign wr_mask = wr_stb & (addr == REG_MASK);
   assign wr_mode = wr_stb & (addr == REG_MODE);
   assign wr_ctrl = wr_stb & (addr == REG_CTRL);

   // Written values act in the write cycle itself, so cond (and hence the
   // next int_req) already sees a new MASK/gen, and channels switch mode
   // on the write edge.
   assign mask_eff = wr_mask ? wrdata[N_CH-1:0] : mask;
   assign mode_eff = wr_mode ? wrdata[N_CH-1:0] : mode;
   assign gen_eff  = wr_ctrl ? wrdata[CTRL_GEN] : gen;

   // PEND W1C, plus a forced clear for channels switching level->edge.
   assign chan_w1c = (wr_pend ? wrdata[N_CH-1:0] : '0)
                   | (wr_mode ? (wrdata[N_CH-1:0] & ~mode) : '0);

   assign act = src ^ SRC_INV;

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      intctl_chan u_chan (
         .clk     (clk),
         .rst     (rst),
         .act     (act[i]),
         .mode    (mode_eff[i]),
         .w1c     (chan_w1c[i]),
         .pending (pending[i])
      );
   end

   // Control registers; unwritten cycles hold their value via the *_eff mux.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask <= '0;
         mode <= '0;
         gen  <= 1'b0;
      end else begin
         mask <= mask_eff;
         mode <= mode_eff;
         gen  <= gen_eff;
      end
   end

   assign cond = gen_eff & |(pending & mask_eff);

`ifdef INTCTL_TIMEOUT_EN
   localparam int CW = $clog2(TMO_CYC + 1);

   logic [CW-1:0] tmo_cnt;
   logic          tmo, inhibit, inhibit_eff, tmo_w1c, fire;

   assign tmo_w1c     = wr_ctrl & wrdata[CTRL_TMO];
   assign fire        = int_req & (tmo_cnt == CW'(TMO_CYC - 1));
   assign inhibit_eff = inhibit & ~tmo_w1c;
   assign req_nxt     = cond & ~inhibit_eff & ~fire;
   assign tmo_rd      = tmo;

   // Count cycles with int_req high; record and inhibit on expiry until
   // cond drops or software clears the status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
         tmo     <= 1'b0;
         inhibit <= 1'b0;
      end else begin
         tmo_cnt <= int_req ? tmo_cnt + 1'b1 : '0;
         tmo     <= fire | (tmo & ~tmo_w1c);
         inhibit <= fire | (inhibit_eff & cond);
      end
   end
`else
   localparam int unused_tmo_cyc = TMO_CYC;

   assign req_nxt = cond;
   assign tmo_rd  = 1'b0;
`endif

   // Registered interrupt request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_req <= 1'b0;
      end else begin
         int_req <= req_nxt;
      end
   end

   assign zint_oe = int_req;

   // Combinational read mux; unused high bits read as zero.
   // NOTE: rddata gets its default before the case so every path assigns
   // it, which keeps this block purely combinational (no inferred latch).
   always_comb begin
      rddata = '0;
      case (addr)
         REG_PEND: rddata[N_CH-1:0] = pending;
         REG_MASK: rddata[N_CH-1:0] = mask;
         REG_MODE: rddata[N_CH-1:0] = mode;
         default: begin
            rddata[CTRL_GEN] = gen;
            rddata[CTRL_TMO] = tmo_rd;
         end
      endcase
   end

endmodule : intctl
